stopwatch_lap_ctrl: RTL and testbench
=====================================

Name: stopwatch_lap_ctrl

Overview:
- Control unit that sequences the stopwatch datapath by driving its run_stop/clear pair. Commands come from debounced board buttons and, optionally, from UART ASCII bytes.
- Adds a lap function: snapshots the running time and freezes the display on that value for a fixed hold time while counting continues.
- Sits between the debouncers/UART RX and the stopwatch datapath plus FND controller.

Parameters:
- HOLD_CYCLES, 300_000_000, lap display hold time in clk cycles (3 s at 100 MHz); counter width is $clog2(HOLD_CYCLES).
- LAP_MAX, 15, saturation value of lap_cnt; lap_cnt width is $clog2(LAP_MAX+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- btn_run  in  1  debounced level, run/stop toggle
- btn_clear  in  1  debounced level, clear
- btn_lap  in  1  debounced level, lap capture
- pc_valid  in  1  one-cycle strobe, pc_data is valid
- pc_data  in  8  ASCII command byte
- cur_msec/cur_sec/cur_min/cur_hour  in  7/6/6/5  live datapath time
- run_stop  out  1  datapath enable
- clear  out  1  datapath clear (effective only while run_stop=0)
- disp_msec/disp_sec/disp_min/disp_hour  out  7/6/6/5  time to FND controller
- lap_hold  out  1  display frozen on lap value
- lap_cnt  out  4  laps taken since last clear

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high on rst. On reset: state=IDLE, run_stop=0, clear=0, lap_hold=0, lap_cnt=0, lap registers=0, hold counter=0, edge registers=0.
- Button edge detect: each button level is registered. A request is recognised in the cycle where the level is 1 and its registered copy is 0. Holding a button produces exactly one request.
- Event merge: a button request and the matching pc command in the same cycle merge into one event.
- Same-cycle priority: clear > run toggle > lap. Lower-priority requests in that cycle are dropped.
- Latency: every output change is visible after the first clk edge following the recognition cycle.
- FSM states: IDLE (stopped at zero), RUN, STOP, CLR.
- IDLE: run→RUN. clear→CLR. lap ignored.
- RUN: run_stop=1. run→STOP. clear ignored. lap→capture.
- STOP: run_stop=0. run→RUN. clear→CLR. lap→cancel hold (lap_hold=0, counter=0).
- CLR: exactly one cycle with clear=1 and run_stop=0. Clears lap registers, lap_cnt and the hold. Unconditionally returns to IDLE; any request in this cycle is dropped.
- clear=0 in every state other than CLR.
- Capture:
  - Latch cur_* into the lap registers and set lap_hold=1.
  - Load the hold counter with HOLD_CYCLES-1.
  - lap_cnt += 1, saturating at LAP_MAX.
  - A capture while lap_hold=1 re-latches and restarts the counter.
- Hold counter: decrements each cycle while lap_hold=1, including in STOP. At 0, lap_hold drops on the next edge.
- Display: disp_* = lap_hold ? lap registers : cur_* (combinational mux).
- RUN→STOP keeps any active hold running.
- Reset mid-operation: asynchronous return to reset values; any in-progress clear is aborted.

Optional Feature:
- Macro PC_CMD_EN.
- When defined: on pc_valid, 'R'/'r' = run toggle, 'C'/'c' = clear, 'L'/'l' = lap. Other bytes are ignored.
- When undefined: pc_valid and pc_data are unused and no command decode logic is synthesized; the ports remain present.

Decomposition:
- Shared package stopwatch_pkg: state encoding (IDLE/RUN/STOP/CLR), ASCII command constants, time field widths (7/6/6/5).
- One natural sub-module: btn_edge_det (registered rising-edge detector), instantiated three times.

Test Plan:
- Reset, then btn_run held high 10 cycles → run_stop=1 one edge after the recognition cycle; a single toggle only. Second press → run_stop=0, state STOP.
- STOP with cur time 00:00:12.34, btn_clear → exactly one cycle clear=1 with run_stop=0, then IDLE, lap_cnt=0. btn_clear during RUN → clear never asserted.
- RUN, btn_lap at cur 00:01:05.50 (HOLD_CYCLES=20 in the bench) → disp shows 05.50 for 20 cycles while cur_* advance, then tracks cur_*, lap_cnt=1.
- btn_run and btn_clear rise in the same cycle while in STOP → clear wins, run_stop stays 0, state IDLE.
- 17 laps in RUN → lap_cnt saturates at 15. A lap at cycle 10 of a hold re-latches and lasts a full 20 cycles.
- With PC_CMD_EN: pc_valid with 'r' → RUN, 'L' → capture, 'x' → no change. Without the macro, 'r' → no change.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_e   : control FSM encoding (IDLE / RUN / STOP / CLR)
//   sw_time_t : packed hour/min/sec/msec time value
//   CMD_*     : ASCII command bytes accepted from the PC link
package stopwatch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    CLR  = 2'd3
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } sw_time_t;

  localparam logic [7:0] CMD_RUN_UC = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RUN_LC = 8'h72;  // 'r'
  localparam logic [7:0] CMD_CLR_UC = 8'h43;  // 'C'
  localparam logic [7:0] CMD_CLR_LC = 8'h63;  // 'c'
  localparam logic [7:0] CMD_LAP_UC = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_LAP_LC = 8'h6C;  // 'l'

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// PC command channel from the UART receiver.
//   pc_valid : one-cycle strobe, pc_data holds a received byte
//   pc_data  : ASCII command byte
// master = UART RX side, slave = stopwatch_lap_ctrl.
interface stopwatch_lap_ctrl_if;
  logic       pc_valid;
  logic [7:0] pc_data;

  modport master (output pc_valid, output pc_data);
  modport slave  (input  pc_valid, input  pc_data);
endinterface

// File: rtl/stopwatch_lap_ctrl_btn_edge_det.sv
// Registered rising-edge detector for one debounced button level.
//   clk, rst : clock, asynchronous active-high reset
//   btn_i    : debounced button level
//   rise_o   : high in the cycle where btn_i is 1 and its registered copy is 0
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control unit: sequences the datapath run_stop/clear pair from
// button and (optionally) PC commands, and implements a lap hold that freezes
// the display on a captured time while the datapath keeps counting.
//   clk, rst            : clock, asynchronous active-high reset
//   btn_run/clear/lap   : debounced button levels
//   pc                  : PC command channel (slave modport)
//   cur_*               : live datapath time
//   run_stop, clear     : datapath control (registered)
//   disp_*              : time shown on the FND (lap value while lap_hold)
//   lap_hold, lap_cnt   : lap hold flag, laps since last clear (saturating)
// Optional feature: define PC_CMD_EN to decode 'R'/'C'/'L' (either case) bytes
// from the PC channel; without it the channel is ignored.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int HOLD_CYCLES = 300_000_000,
  parameter int LAP_MAX     = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_run,
  input  logic                           btn_clear,
  input  logic                           btn_lap,
  stopwatch_lap_ctrl_if.slave            pc,
  input  logic [MSEC_W-1:0]              cur_msec,
  input  logic [SEC_W-1:0]               cur_sec,
  input  logic [MIN_W-1:0]               cur_min,
  input  logic [HOUR_W-1:0]              cur_hour,
  output logic                           run_stop,
  output logic                           clear,
  output logic [MSEC_W-1:0]              disp_msec,
  output logic [SEC_W-1:0]               disp_sec,
  output logic [MIN_W-1:0]               disp_min,
  output logic [HOUR_W-1:0]              disp_hour,
  output logic                           lap_hold,
  output logic [$clog2(LAP_MAX+1)-1:0]   lap_cnt
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int LAP_W  = $clog2(LAP_MAX + 1);

  logic run_rise, clr_rise, lap_rise;
  logic pc_run, pc_clr, pc_lap;
  logic run_ev, clr_ev, lap_ev;

  state_e            state_q,    state_d;
  logic              run_stop_q, run_stop_d;
  logic              clear_q,    clear_d;
  logic              lap_hold_q, lap_hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [LAP_W-1:0]  lap_cnt_q,  lap_cnt_d;
  sw_time_t          lap_q,      lap_d;
  sw_time_t          cur_time;

  btn_edge_det u_run_edge (.clk(clk), .rst(rst), .btn_i(btn_run),   .rise_o(run_rise));
  btn_edge_det u_clr_edge (.clk(clk), .rst(rst), .btn_i(btn_clear), .rise_o(clr_rise));
  btn_edge_det u_lap_edge (.clk(clk), .rst(rst), .btn_i(btn_lap),   .rise_o(lap_rise));

`ifdef PC_CMD_EN
  assign pc_run = pc.pc_valid & ((pc.pc_data == CMD_RUN_UC) || (pc.pc_data == CMD_RUN_LC));
  assign pc_clr = pc.pc_valid & ((pc.pc_data == CMD_CLR_UC) || (pc.pc_data == CMD_CLR_LC));
  assign pc_lap = pc.pc_valid & ((pc.pc_data == CMD_LAP_UC) || (pc.pc_data == CMD_LAP_LC));
`else
  // Channel kept on the port list but deliberately left dangling.
  logic unused_pc;
  assign unused_pc = ^{pc.pc_valid, pc.pc_data};
  assign pc_run    = 1'b0;
  assign pc_clr    = 1'b0;
  assign pc_lap    = 1'b0;
`endif

  // Button and PC sources merge into one event; clear beats run beats lap,
  // and a losing request is dropped rather than deferred.
  assign clr_ev = clr_rise | pc_clr;
  assign run_ev = (run_rise | pc_run) & ~clr_ev;
  assign lap_ev = (lap_rise | pc_lap) & ~clr_ev & ~(run_rise | pc_run);

  assign cur_time = '{hour: cur_hour, min: cur_min, sec: cur_sec, msec: cur_msec};

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    hold_cnt_d = hold_cnt_q;
    lap_cnt_d  = lap_cnt_q;
    lap_d      = lap_q;

    // Hold countdown runs in any state; a capture below overrides it.
    if (lap_hold_q) begin
      if (hold_cnt_q == '0) lap_hold_d = 1'b0;
      else                  hold_cnt_d = hold_cnt_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (clr_ev)      state_d = CLR;
        else if (run_ev) state_d = RUN;
      end
      RUN: begin
        if (run_ev) begin
          state_d = STOP;
        end else if (lap_ev) begin
          lap_d      = cur_time;
          lap_hold_d = 1'b1;
          hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
          if (lap_cnt_q != LAP_W'(LAP_MAX)) lap_cnt_d = lap_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clr_ev) begin
          state_d = CLR;
        end else if (run_ev) begin
          state_d = RUN;
        end else if (lap_ev) begin
          lap_hold_d = 1'b0;
          hold_cnt_d = '0;
        end
      end
      CLR: begin
        state_d    = IDLE;
        lap_d      = '0;
        lap_cnt_d  = '0;
        lap_hold_d = 1'b0;
        hold_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    run_stop_d = (state_d == RUN);
    clear_d    = (state_d == CLR);
  end

  // NOTE: every flop, including the lap time registers, takes a defined reset
  // value; an abort mid-clear must leave no stale lap data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      run_stop_q <= 1'b0;
      clear_q    <= 1'b0;
      lap_hold_q <= 1'b0;
      hold_cnt_q <= '0;
      lap_cnt_q  <= '0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_stop_q <= run_stop_d;
      clear_q    <= clear_d;
      lap_hold_q <= lap_hold_d;
      hold_cnt_q <= hold_cnt_d;
      lap_cnt_q  <= lap_cnt_d;
      lap_q      <= lap_d;
    end
  end

  assign run_stop  = run_stop_q;
  assign clear     = clear_q;
  assign lap_hold  = lap_hold_q;
  assign lap_cnt   = lap_cnt_q;
  assign disp_msec = lap_hold_q ? lap_q.msec : cur_msec;
  assign disp_sec  = lap_hold_q ? lap_q.sec  : cur_sec;
  assign disp_min  = lap_hold_q ? lap_q.min  : cur_min;
  assign disp_hour = lap_hold_q ? lap_q.hour : cur_hour;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
module tb_stopwatch_lap_ctrl;
  import stopwatch_pkg::*;

  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run, btn_clear, btn_lap;
  logic [6:0]  cur_msec, disp_msec;
  logic [5:0]  cur_sec, disp_sec;
  logic [5:0]  cur_min, disp_min;
  logic [4:0]  cur_hour, disp_hour;
  logic        run_stop, clear, lap_hold;
  logic [3:0]  lap_cnt;

  int n_run  = 0;
  int n_fail = 0;

  stopwatch_lap_ctrl_if pc_if ();

  stopwatch_lap_ctrl #(.HOLD_CYCLES(HOLD), .LAP_MAX(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_lap   (btn_lap),
    .pc        (pc_if),
    .cur_msec  (cur_msec),
    .cur_sec   (cur_sec),
    .cur_min   (cur_min),
    .cur_hour  (cur_hour),
    .run_stop  (run_stop),
    .clear     (clear),
    .disp_msec (disp_msec),
    .disp_sec  (disp_sec),
    .disp_min  (disp_min),
    .disp_hour (disp_hour),
    .lap_hold  (lap_hold),
    .lap_cnt   (lap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s, input int ms);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
    cur_msec = 7'(ms);
  endtask

  task automatic pc_send(input logic [7:0] b);
    pc_if.pc_valid = 1'b1;
    pc_if.pc_data  = b;
    step(1);
    pc_if.pc_valid = 1'b0;
    pc_if.pc_data  = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1;
    btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    pc_if.pc_valid = 1'b0;
    pc_if.pc_data  = 8'h00;
    set_cur(1, 2, 3, 4);
    #12;
    check("rst_run_stop", 32'(run_stop), 0);
    check("rst_clear",    32'(clear), 0);
    check("rst_lap_hold", 32'(lap_hold), 0);
    check("rst_lap_cnt",  32'(lap_cnt), 0);
    check("rst_state",    32'(dut.state_q), 32'(IDLE));
    check("rst_disp",     32'({disp_hour, disp_min, disp_sec, disp_msec}),
                          32'({5'd1, 6'd2, 6'd3, 7'd4}));
    step(1);
    rst = 1'b0;
    step(1);

    // Run press held for 10 cycles: one toggle only.
    btn_run = 1'b1;
    check("run_pre_edge", 32'(run_stop), 0);
    step(1);
    check("run_one_edge", 32'(run_stop), 1);
    step(9);
    check("run_held", 32'(run_stop), 1);
    check("run_state", 32'(dut.state_q), 32'(RUN));
    btn_run = 1'b0;
    step(1);
    btn_run = 1'b1;
    step(1);
    btn_run = 1'b0;
    check("stop_run_stop", 32'(run_stop), 0);
    check("stop_state", 32'(dut.state_q), 32'(STOP));
    step(1);

    // Clear from STOP at 00:00:12.34: exactly one clear cycle.
    set_cur(0, 0, 12, 34);
    btn_clear = 1'b1;
    step(1);
    check("clr_pulse", 32'({clear, run_stop}), 32'({1'b1, 1'b0}));
    step(1);
    btn_clear = 1'b0;
    check("clr_done", 32'(clear), 0);
    check("clr_idle", 32'(dut.state_q), 32'(IDLE));
    step(1);

    // Clear while running is ignored.
    btn_run = 1'b1; step(1); btn_run = 1'b0; step(1);
    btn_clear = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step(1);
      if (clear) seen = 1'b1;
    end
    check("clr_in_run", 32'(seen), 0);
    check("clr_in_run_rs", 32'(run_stop), 1);
    btn_clear = 1'b0;
    step(1);

    // Lap at 00:01:05.50: display frozen for HOLD cycles while time advances.
    set_cur(0, 1, 5, 50);
    btn_lap = 1'b1;
    step(1);
    btn_lap = 1'b0;
    check("lap_cnt_1", 32'(lap_cnt), 1);
    for (int i = 0; i < HOLD; i++) begin
      check("lap_frozen", 32'({lap_hold, disp_min, disp_sec, disp_msec}),
                          32'({1'b1, 6'd1, 6'd5, 7'd50}));
      cur_msec = 7'(51 + i);
      step(1);
    end
    check("lap_release", 32'({lap_hold, disp_msec}), 32'({1'b0, 7'd70}));
    check("lap_cnt_keep", 32'(lap_cnt), 1);

    // Run and clear rise together in STOP: clear wins.
    btn_run = 1'b1; step(1); btn_run = 1'b0; step(1);
    check("prio_stop", 32'(dut.state_q), 32'(STOP));
    btn_run = 1'b1; btn_clear = 1'b1;
    step(1);
    btn_run = 1'b0; btn_clear = 1'b0;
    check("prio_clear", 32'({clear, run_stop}), 32'({1'b1, 1'b0}));
    step(1);
    check("prio_idle", 32'(dut.state_q), 32'(IDLE));
    check("prio_rs", 32'({clear, run_stop}), 0);
    check("prio_lap_cnt", 32'(lap_cnt), 0);

    // 17 laps saturate lap_cnt at 15.
    btn_run = 1'b1; step(1); btn_run = 1'b0; step(1);
    for (int k = 0; k < 17; k++) begin
      btn_lap = 1'b1; step(1); btn_lap = 1'b0; step(1);
      if (k == 13) check("lap_cnt_14", 32'(lap_cnt), 14);
    end
    check("lap_sat", 32'(lap_cnt), 15);
    step(25);
    check("hold_expired", 32'(lap_hold), 0);

    // Re-capture at hold cycle 10 restarts a full hold.
    set_cur(0, 0, 0, 10);
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
    step(9);
    check("hold_c10", 32'({lap_hold, disp_msec}), 32'({1'b1, 7'd10}));
    cur_msec = 7'd77;
    btn_lap = 1'b1;
    step(1);
    btn_lap = 1'b0;
    cur_msec = 7'd3;
    check("relatch", 32'({lap_hold, disp_msec}), 32'({1'b1, 7'd77}));
    step(HOLD - 1);
    check("relatch_end", 32'({lap_hold, disp_msec}), 32'({1'b1, 7'd77}));
    step(1);
    check("relatch_drop", 32'({lap_hold, disp_msec}), 32'({1'b0, 7'd3}));

    // Hold survives RUN->STOP, and a lap in STOP cancels it.
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
    btn_run = 1'b1; step(1); btn_run = 1'b0;
    check("hold_in_stop", 32'({lap_hold, run_stop}), 32'({1'b1, 1'b0}));
    step(3);
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
    check("stop_lap_cancel", 32'(lap_hold), 0);
    check("stop_lap_state", 32'(dut.state_q), 32'(STOP));
    step(1);

    // PC command channel.
    btn_clear = 1'b1; step(1); btn_clear = 1'b0; step(1);
    check("pc_idle", 32'(dut.state_q), 32'(IDLE));
    pc_send(8'h72);  // 'r'
`ifdef PC_CMD_EN
    check("pc_r", 32'(run_stop), 1);
`else
    check("pc_r", 32'(run_stop), 0);
`endif
    pc_send(8'h78);  // 'x'
`ifdef PC_CMD_EN
    check("pc_x", 32'(run_stop), 1);
`else
    check("pc_x", 32'(run_stop), 0);
`endif
    pc_send(8'h4C);  // 'L'
`ifdef PC_CMD_EN
    check("pc_L", 32'(lap_hold), 1);
`else
    check("pc_L", 32'(lap_hold), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
